// File: rtl/demux_dispatch.sv
// Buffered command sequencer feeding a 1-to-8 demux: FIFO of {sel, a} commands, each held HOLD_CYCLES cycles.
// Optional break-before-make GAP cycle after each command when DEMUX_DISPATCH_GAP_EN is defined.
module demux_dispatch #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_sel,
  input  logic                     in_a,
  output logic [2:0]               sel,
  output logic                     a,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state;
  logic [7:0]    hold_cnt;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          decide;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = decide && !empty;

  // decide: the edge on which the dispatcher picks the next command or falls back to IDLE
  always_comb begin
    // NOTE: default first so every path assigns decide and no latch is inferred.
    decide = 1'b0;
`ifdef DEMUX_DISPATCH_GAP_EN
    decide = (state == ST_IDLE) || (state == ST_GAP);
`else
    decide = (state == ST_IDLE) || ((state == ST_HOLD) && (hold_cnt == '0));
`endif
  end

  // NOTE: storage is not reset; stale entries are unreachable once pointers and level clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sel, in_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      sel      <= '0;
      a        <= 1'b0;
      busy     <= 1'b0;
    end else if (decide) begin
      if (!empty) begin
        sel      <= mem[rd_ptr][3:1];
        a        <= mem[rd_ptr][0];
        hold_cnt <= HOLD_LOAD;
        state    <= ST_HOLD;
        busy     <= 1'b1;
      end else begin
        a        <= 1'b0;
        state    <= ST_IDLE;
        busy     <= 1'b0;
      end
    end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - 1'b1;
`ifdef DEMUX_DISPATCH_GAP_EN
    end else if (state == ST_HOLD) begin
      // break-before-make: drop a for one cycle while sel stays put
      state <= ST_GAP;
      a     <= 1'b0;
`endif
    end
  end

endmodule
